// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- 32-bit signed restoring divider, one quotient bit per clock
//
// A rising edge on DivCtrl while idle starts an operation. The unit latches the
// operand magnitudes and the result signs, then runs 32 restoring-division
// steps. A final cycle applies the signs and presents the results.
// Division truncates toward zero, and the remainder takes the sign of the
// dividend. A zero divisor ends the operation after one cycle with DivZero set.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   RegAOut   in   [31:0] dividend, two's complement
//   RegBOut   in   [31:0] divisor, two's complement
//   DivCtrl   in   start/hold request; dropping it mid-run aborts the operation
//   DivDone   out  one-cycle completion pulse (normal or divide-by-zero)
//   DivZero   out  divide-by-zero flag, held until the next start
//   DivHIOut  out  [31:0] remainder
//   DivLOOut  out  [31:0] quotient
// -----------------------------------------------------------------------------
module div_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] RegAOut,
   input  logic [31:0] RegBOut,
   input  logic        DivCtrl,
   output logic        DivDone,
   output logic        DivZero,
   output logic [31:0] DivHIOut,
   output logic [31:0] DivLOOut
);

   typedef enum logic [1:0] {IDLE, RUN, SIGN, ZERO} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;       // partial remainder (magnitude)
   logic [31:0] quo_q, quo_d;       // dividend shifts out of the top while quotient bits shift in
   logic [31:0] dvs_q, dvs_d;       // divisor magnitude
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        ctrl_prev_q;
   logic        done_q, done_d;
   logic        zero_q, zero_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] a_mag, b_mag;
   logic [32:0] shifted;
   logic [32:0] trial;

   // The magnitude of 0x80000000 is 0x80000000, read as unsigned.
   assign a_mag = RegAOut[31] ? (~RegAOut + 32'd1) : RegAOut;
   assign b_mag = RegBOut[31] ? (~RegBOut + 32'd1) : RegBOut;

   // A 33-bit trial is wide enough because the shifted remainder is always
   // below twice the divisor magnitude, and that magnitude is at most 2^31.
   // Bit 32 of the difference is therefore a reliable borrow flag.
   assign shifted = {rem_q, quo_q[31]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         ctrl_prev_q <= 1'b0;
         done_q      <= 1'b0;
         zero_q      <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         ctrl_prev_q <= DivCtrl;
         done_q      <= done_d;
         zero_q      <= zero_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      done_d    = 1'b0;
      zero_d    = zero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      unique case (state_q)
         IDLE: begin
            // Start only on a rising edge, so a request held high does not restart.
            if (DivCtrl && !ctrl_prev_q) begin
               quo_d     = a_mag;
               dvs_d     = b_mag;
               rem_d     = '0;
               cnt_d     = '0;
               neg_rem_d = RegAOut[31];
               neg_quo_d = RegAOut[31] ^ RegBOut[31];
               zero_d    = 1'b0;
               state_d   = (RegBOut == 32'd0) ? ZERO : RUN;
            end
         end

         RUN: begin
            if (!DivCtrl) begin
               // Abort: discard the operation and leave the results untouched.
               state_d = IDLE;
            end else begin
               if (!trial[32]) begin
                  rem_d = trial[31:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = {rem_q[30:0], quo_q[31]};
                  quo_d = {quo_q[30:0], 1'b0};
               end
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = SIGN;
               end
            end
         end

         SIGN: begin
            // 0x80000000 / -1 gives a positive quotient of 0x80000000, which
            // wraps to 0x80000000 in 32 bits. No flag is raised.
            lo_d    = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
            hi_d    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
            done_d  = 1'b1;
            zero_d  = 1'b0;
            state_d = IDLE;
         end

         ZERO: begin
            done_d  = 1'b1;
            zero_d  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign DivDone  = done_q;
   assign DivZero  = zero_q;
   assign DivHIOut = hi_q;
   assign DivLOOut = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit
//
// Contents: a table of directed vectors, randomized operands checked against a
// plain-arithmetic signed-division model, and hand-written sequences for
// abort, asynchronous reset, and start on reset release.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] RegAOut = '0;
   logic [31:0] RegBOut = '0;
   logic        DivCtrl = 1'b0;
   logic        DivDone;
   logic        DivZero;
   logic [31:0] DivHIOut;
   logic [31:0] DivLOOut;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] model_lo = '0;
   logic [31:0] model_hi = '0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        zero;
   } vec_t;

   vec_t vecs [12];

   div_unit dut (
      .clock    (clock),
      .reset    (reset),
      .RegAOut  (RegAOut),
      .RegBOut  (RegBOut),
      .DivCtrl  (DivCtrl),
      .DivDone  (DivDone),
      .DivZero  (DivZero),
      .DivHIOut (DivHIOut),
      .DivLOOut (DivLOOut)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Reference: signed division that truncates toward zero. The one overflow
   // case (most negative value divided by -1) wraps.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] lo, output logic [31:0] hi);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         lo = 32'h8000_0000;
         hi = 32'd0;
      end else begin
         lo = 32'(sa / sb);
         hi = 32'(sa % sb);
      end
   endtask

   // Called at the negedge that follows the start edge t0.
   task automatic wait_result(input logic [31:0] elo, input logic [31:0] ehi,
                              input logic ezero, input string nm);
      int   lat = 0;
      logic extra = 1'b0;
      while (DivDone !== 1'b1 && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), ezero ? 32'd1 : 32'd33);
      chk({nm, " lo"}, DivLOOut, elo);
      chk({nm, " hi"}, DivHIOut, ehi);
      chk({nm, " zero"}, {31'd0, DivZero}, {31'd0, ezero});
      @(negedge clock);
      chk({nm, " done pulse width"}, {31'd0, DivDone}, 32'd0);
      // DivCtrl is still high here; it must not cause a restart.
      repeat (3) begin
         @(negedge clock);
         if (DivDone) extra = 1'b1;
      end
      chk({nm, " no restart"}, {31'd0, extra}, 32'd0);
      chk({nm, " zero held"}, {31'd0, DivZero}, {31'd0, ezero});
      model_lo = elo;
      model_hi = ehi;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic ezero, input string nm);
      @(negedge clock);
      DivCtrl = 1'b0;
      @(negedge clock);
      RegAOut = a;
      RegBOut = b;
      DivCtrl = 1'b1;
      @(negedge clock);
      // Operands are scrambled after t0; the result must not depend on them.
      RegAOut = $urandom;
      RegBOut = $urandom;
      wait_result(elo, ehi, ezero, nm);
      $display("op %s: a=%h b=%h lo=%h hi=%h zero=%b", nm, a, b, DivLOOut, DivHIOut, DivZero);
   endtask

   initial begin
      logic [31:0] ra, rb, elo, ehi;
      logic        ez;
      logic        seen;

      vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1]  = '{32'h0000_DEAD,  32'd0,          32'd14,         32'd2,          1'b1};
      vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[3]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
      vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
      vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
      vecs[6]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
      vecs[7]  = '{32'd5,          32'd100,        32'd0,          32'd5,          1'b0};
      vecs[8]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
      vecs[9]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
      vecs[10] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
      vecs[11] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};

      // Reset state
      #1;
      chk("reset lo", DivLOOut, 32'd0);
      chk("reset hi", DivHIOut, 32'd0);
      chk("reset done", {31'd0, DivDone}, 32'd0);
      chk("reset zero", {31'd0, DivZero}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].zero,
                $sformatf("vec%0d", i));
      end

      // Randomized operands against the reference model
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(0, 20)) - 32'd10;
         else                           rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
         if (rb == 32'd0) begin
            elo = model_lo;
            ehi = model_hi;
            ez  = 1'b1;
         end else begin
            ref_div(ra, rb, elo, ehi);
            ez = 1'b0;
         end
         run_op(ra, rb, elo, ehi, ez, $sformatf("rnd%0d", i));
      end

      // Abort: start 100/7, sample DivCtrl low at t10
      run_op(32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 32'd1, 1'b0, "pre_abort");
      @(negedge clock);
      DivCtrl = 1'b0;
      @(negedge clock);
      RegAOut = 32'd100;
      RegBOut = 32'd7;
      DivCtrl = 1'b1;
      @(negedge clock);
      repeat (9) @(negedge clock);
      DivCtrl = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (DivDone) seen = 1'b1;
      end
      chk("abort no done", {31'd0, seen}, 32'd0);
      chk("abort lo kept", DivLOOut, model_lo);
      chk("abort hi kept", DivHIOut, model_hi);
      $display("op abort: lo=%h hi=%h", DivLOOut, DivHIOut);
      run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "restart");

      // Asynchronous reset mid-run, between t14 and t15
      @(negedge clock);
      DivCtrl = 1'b0;
      @(negedge clock);
      RegAOut = 32'd1000;
      RegBOut = 32'd3;
      DivCtrl = 1'b1;
      @(negedge clock);
      repeat (14) @(negedge clock);
      #2;
      reset   = 1'b0;
      DivCtrl = 1'b0;
      #1;
      chk("async reset lo", DivLOOut, 32'd0);
      chk("async reset hi", DivHIOut, 32'd0);
      chk("async reset done", {31'd0, DivDone}, 32'd0);
      model_lo = '0;
      model_hi = '0;
      @(negedge clock);
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (DivDone) seen = 1'b1;
      end
      chk("post reset no done", {31'd0, seen}, 32'd0);
      chk("post reset lo", DivLOOut, 32'd0);
      $display("op reset_mid_run: lo=%h hi=%h", DivLOOut, DivHIOut);

      // DivCtrl already high when reset releases: the first edge is a start
      @(negedge clock);
      reset   = 1'b0;
      RegAOut = 32'hFFFF_FF9C;
      RegBOut = 32'd7;
      DivCtrl = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      RegAOut = $urandom;
      RegBOut = $urandom;
      wait_result(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "start_at_release");
      $display("op start_at_release: lo=%h hi=%h", DivLOOut, DivHIOut);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters SHALL be none; the datapath is fixed at 32 bits.
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces reset state immediately, independent of clock.
REQ-004 RegAOut  in  32  dividend, two's complement.
REQ-005 RegBOut  in  32  divisor, two's complement.
REQ-006 DivCtrl  in  1  start/hold request from control unit.
REQ-007 DivDone  out  1  one-cycle completion pulse (normal or divide-by-zero).
REQ-008 DivZero  out  1  divide-by-zero flag, valid with DivDone.
REQ-009 DivHIOut  out  32  remainder.
REQ-010 DivLOOut  out  32  quotient.

Function
REQ-011 States SHALL be IDLE, RUN, SIGN, ZERO; reset state IDLE.
REQ-012 Start SHALL occur only on a DivCtrl rising edge (DivCtrl=1 this edge, 0 at previous edge, registered) while in IDLE; a level held high after completion SHALL NOT restart.
REQ-013 Start edge t0: capture |RegAOut|, |RegBOut|, sign(A), sign(A) XOR sign(B); clear remainder accumulator and iteration counter; go RUN, or ZERO if RegBOut==0.
REQ-014 RUN: one restoring-division step per edge (shift {rem,quot} left 1, trial-subtract divisor magnitude, keep if non-negative, set quotient LSB); 33-bit trial width, no overflow.
REQ-015 RUN SHALL last exactly 32 edges (t1..t32), 6-bit counter, then SIGN.
REQ-016 SIGN, edge t33: write DivLOOut = quotient negated if quotient sign bit set; DivHIOut = remainder negated if dividend negative; DivDone=1; DivZero=0; go IDLE.
REQ-017 Results SHALL truncate toward zero; remainder sign SHALL equal dividend sign (or be zero).
REQ-018 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0 (32-bit wrap, no flag).
REQ-019 ZERO, edge t1: DivDone=1, DivZero=1, DivHIOut/DivLOOut unchanged; go IDLE.
REQ-020 DivDone SHALL be high exactly one cycle (cleared at the following edge); DivZero SHALL hold until the next start edge.
REQ-021 DivCtrl sampled low during RUN SHALL abort to IDLE at that edge: no DivDone, outputs unchanged.
REQ-022 DivHIOut/DivLOOut SHALL change only at SIGN edge or reset; stable between operations.
REQ-023 Operand changes after t0 SHALL NOT affect the result.

Reset
REQ-024 reset low SHALL asynchronously set state IDLE, counter 0, accumulators 0, DivDone=0, DivZero=0, DivHIOut=0, DivLOOut=0, previous-DivCtrl register 0.
REQ-025 reset asserted mid-RUN SHALL discard the operation; after release a fresh DivCtrl rising edge is required.
REQ-026 First clock edge after reset release with DivCtrl already high SHALL count as a rising edge.

Verification
REQ-027 A=100, B=7, DivCtrl rises at t0 and held -> at t33 LO=14, HI=2, DivDone=1 one cycle, DivZero=0.
REQ-028 A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); A=7, B=0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
REQ-029 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DivZero=0 at t33.
REQ-030 B=0, prior outputs LO=14/HI=2 -> at t1 DivDone=1, DivZero=1, LO=14, HI=2 unchanged; no further DivDone while DivCtrl stays high.
REQ-031 Start 100/7, drop DivCtrl at t10 -> IDLE, no DivDone, outputs unchanged; re-raise DivCtrl -> correct result 33 edges later.
REQ-032 Start, assert reset low mid-cycle at t15 -> outputs 0 immediately without a clock edge; no DivDone after release until new start.
